// File: rtl/uart_alici_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority voting,
// optional parity and 1/2 stop bits, FWFT FIFO holding data plus error flags.
module uart_alici_param #(
  parameter int unsigned VERI_W        = 8,
  parameter int unsigned FIFO_DERINLIK = 16,
  parameter int unsigned SAYAC_W       = 16
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [SAYAC_W-1:0]               baud_bolen_i,
  input  logic [1:0]                       parite_i,
  input  logic                             dur2_i,
  input  logic                             rx_en_i,
  input  logic                             rx_i,
  input  logic                             oku_en_i,
  input  logic                             hata_temizle_i,
  output logic [VERI_W-1:0]                veri_o,
  output logic                             parite_hata_o,
  output logic                             cerceve_hata_o,
  output logic                             fifo_bos_o,
  output logic                             fifo_dolu_o,
  output logic [$clog2(FIFO_DERINLIK):0]   doluluk_o,
  output logic                             tasma_o
);

  localparam int unsigned AW = $clog2(FIFO_DERINLIK);
  localparam int unsigned EW = VERI_W + 2;

  typedef enum logic [2:0] {StBosta, StBasla, StVeri, StParite, StDur} state_e;

  state_e              state_q, state_d;
  logic [SAYAC_W-1:0]  cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [VERI_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic [1:0]          samp_q, samp_d;
  logic                sync1_q, sync2_q, prev_q;

  logic                rx_s, fall;
  logic [SAYAC_W-1:0]  half;
  logic                decide, bit_end, vote;
  logic                par_on, par_exp;
  logic                push;
  logic [EW-1:0]       push_word;

  assign rx_s    = sync2_q;
  assign fall    = prev_q & ~sync2_q;
  assign half    = baud_bolen_i >> 1;
  assign decide  = (cnt_q == half + SAYAC_W'(1));
  assign bit_end = (cnt_q == baud_bolen_i - SAYAC_W'(1));
  // Third sample is the live synchronised input at the decision point.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign par_on  = (parite_i == 2'b01) || (parite_i == 2'b10);
  assign par_exp = (parite_i == 2'b10) ? ~(^data_q) : ^data_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + SAYAC_W'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    samp_d  = samp_q;
    push    = 1'b0;

    if (cnt_q == half - SAYAC_W'(1)) samp_d[0] = rx_s;
    if (cnt_q == half)               samp_d[1] = rx_s;
    if (bit_end) begin
      cnt_d = '0;
      bit_d = bit_q + 4'd1;
    end

    unique case (state_q)
      StBosta: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall && rx_en_i) begin
          state_d = StBasla;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      StBasla: begin
        if (decide && vote) begin
          state_d = StBosta;
          cnt_d   = '0;
          bit_d   = '0;
        end else if (bit_end) begin
          state_d = StVeri;
          bit_d   = '0;
        end
      end
      StVeri: begin
        if (decide) data_d = {vote, data_q[VERI_W-1:1]};
        if (bit_end && (bit_q == 4'(VERI_W - 1))) begin
          bit_d   = '0;
          state_d = par_on ? StParite : StDur;
        end
      end
      StParite: begin
        if (decide) perr_d = (vote != par_exp);
        if (bit_end) begin
          bit_d   = '0;
          state_d = StDur;
        end
      end
      StDur: begin
        if (decide) begin
          ferr_d = ferr_q | ~vote;
          // Leave at mid final stop bit so a back-to-back start edge is not missed.
          if (bit_q == {3'b000, dur2_i}) begin
            push    = 1'b1;
            state_d = StBosta;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
      end
      default: begin
        state_d = StBosta;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    if ((state_q != StBosta) && !rx_en_i) begin
      state_d = StBosta;
      cnt_d   = '0;
      bit_d   = '0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StBosta;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      samp_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      samp_q  <= samp_d;
    end
  end

  assign push_word = {ferr_d, perr_q, data_q};

  logic [EW-1:0] mem [FIFO_DERINLIK];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          empty, full, wr, rd;
  logic [EW-1:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(FIFO_DERINLIK));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr    = push && (!full || oku_en_i);
  assign rd    = oku_en_i && !empty;

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr_q] <= push_word;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      tasma_o <= 1'b0;
    end else begin
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (rd) rptr_q <= rptr_q + AW'(1);
      if (wr && !rd)      count_q <= count_q + (AW+1)'(1);
      else if (rd && !wr) count_q <= count_q - (AW+1)'(1);
      if (push && full && !oku_en_i) tasma_o <= 1'b1;
      else if (hata_temizle_i)       tasma_o <= 1'b0;
    end
  end

  assign head           = mem[rptr_q];
  assign veri_o         = empty ? '0 : head[VERI_W-1:0];
  assign parite_hata_o  = empty ? 1'b0 : head[VERI_W];
  assign cerceve_hata_o = empty ? 1'b0 : head[VERI_W+1];
  assign fifo_bos_o     = empty;
  assign fifo_dolu_o    = full;
  assign doluluk_o      = count_q;

endmodule

// File: tb/tb_uart_alici_param.sv
// Bench for uart_alici_param: directed scenarios plus random frames, checked against
// a queue-based model of the received-frame FIFO.
module tb_uart_alici_param;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [15:0] baud_bolen_i;
  logic [1:0]  parite_i;
  logic        dur2_i, rx_en_i, rx_i, oku_en_i, hata_temizle_i;
  logic [7:0]  veri_o;
  logic        parite_hata_o, cerceve_hata_o, fifo_bos_o, fifo_dolu_o, tasma_o;
  logic [2:0]  doluluk_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] q[$];
  logic       tasma_m;

  always #5 clk = ~clk;

  uart_alici_param #(
    .VERI_W(8),
    .FIFO_DERINLIK(DEPTH),
    .SAYAC_W(16)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn_i),
    .baud_bolen_i(baud_bolen_i),
    .parite_i(parite_i),
    .dur2_i(dur2_i),
    .rx_en_i(rx_en_i),
    .rx_i(rx_i),
    .oku_en_i(oku_en_i),
    .hata_temizle_i(hata_temizle_i),
    .veri_o(veri_o),
    .parite_hata_o(parite_hata_o),
    .cerceve_hata_o(cerceve_hata_o),
    .fifo_bos_o(fifo_bos_o),
    .fifo_dolu_o(fifo_dolu_o),
    .doluluk_o(doluluk_o),
    .tasma_o(tasma_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every observable output against the model queue.
  task automatic check_state(input string tag, input bit at_reset);
    check({tag, "_count"}, 32'(doluluk_o), 32'(q.size()));
    check({tag, "_empty"}, 32'(fifo_bos_o), 32'(q.size() == 0));
    check({tag, "_full"},  32'(fifo_dolu_o), 32'(q.size() == DEPTH));
    check({tag, "_ovf"},   32'(tasma_o), 32'(tasma_m));
    if (q.size() > 0) begin
      check({tag, "_data"}, 32'(veri_o), 32'(q[0][7:0]));
      check({tag, "_perr"}, 32'(parite_hata_o), 32'(q[0][8]));
      check({tag, "_ferr"}, 32'(cerceve_hata_o), 32'(q[0][9]));
    end else if (at_reset) begin
      check({tag, "_data0"}, 32'(veri_o), 32'h0);
      check({tag, "_errs0"}, 32'({parite_hata_o, cerceve_hata_o}), 32'h0);
    end
  endtask

  function automatic logic [9:0] exp_entry(input logic [7:0] d, input logic [1:0] par,
                                           input logic two, input logic bad_par,
                                           input logic s1, input logic s2);
    logic perr, ferr;
    perr = ((par == 2'b01) || (par == 2'b10)) && bad_par;
    ferr = !s1 || (two && !s2);
    return {ferr, perr, d};
  endfunction

  function automatic void model_push(input logic [9:0] e);
    if (q.size() == DEPTH) tasma_m = 1'b1;
    else q.push_back(e);
  endfunction

  task automatic drive_bit(input logic v, input int b, input int glitch_at);
    for (int k = 0; k < b; k++) begin
      @(negedge clk);
      rx_i = (k == glitch_at) ? ~v : v;
    end
  endtask

  // Full frame followed by one idle bit period; gbit selects a data bit to glitch.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic s1,
                            input logic s2, input int gbit);
    int b;
    logic pb;
    b = int'(baud_bolen_i);
    drive_bit(1'b0, b, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], b, (i == gbit) ? (b / 2 + 1) : -1);
    if ((parite_i == 2'b01) || (parite_i == 2'b10)) begin
      pb = (parite_i == 2'b01) ? ^d : ~(^d);
      drive_bit(pb ^ bad_par, b, -1);
    end
    drive_bit(s1, b, -1);
    if (dur2_i) drive_bit(s2, b, -1);
    drive_bit(1'b1, b, -1);
  endtask

  task automatic frame_and_model(input logic [7:0] d, input logic bad_par, input logic s1,
                                 input logic s2, input int gbit);
    send_frame(d, bad_par, s1, s2, gbit);
    model_push(exp_entry(d, parite_i, dur2_i, bad_par, s1, s2));
  endtask

  task automatic pop_one(input string tag);
    check_state(tag, 1'b0);
    @(negedge clk);
    oku_en_i = 1'b1;
    @(negedge clk);
    oku_en_i = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic partial_frame(input int cycles_into_bit4);
    drive_bit(1'b0, 16, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 16, -1);
    drive_bit(1'b0, cycles_into_bit4, -1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn_i = 1'b0; rx_i = 1'b1; rx_en_i = 1'b1; baud_bolen_i = 16'd16;
    parite_i = 2'b00; dur2_i = 1'b0; oku_en_i = 1'b0; hata_temizle_i = 1'b0;
    tasma_m = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset", 1'b1);
    rstn_i = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with exact push latency measured from the pin edge.
    n = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
      begin
        @(negedge clk);
        for (int k = 0; k < 400; k++) begin
          @(posedge clk);
          #1;
          n++;
          if (!fifo_bos_o) break;
        end
      end
    join
    check("push_latency", 32'(n), 32'd157);
    model_push(exp_entry(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    pop_one("a5");
    check_state("a5_popped", 1'b0);

    parite_i = 2'b01;
    frame_and_model(8'h07, 1'b1, 1'b1, 1'b1, -1);
    pop_one("even_bad");
    parite_i = 2'b10;
    frame_and_model(8'h07, 1'b0, 1'b1, 1'b1, -1);
    pop_one("odd_ok");

    parite_i = 2'b00; dur2_i = 1'b1;
    frame_and_model(8'hC3, 1'b0, 1'b1, 1'b0, -1);
    pop_one("stop2_low");
    frame_and_model(8'hC3, 1'b0, 1'b1, 1'b1, -1);
    pop_one("stop2_ok");
    dur2_i = 1'b0;

    // Short low pulse must be rejected as a false start.
    drive_bit(1'b0, 5, -1);
    drive_bit(1'b1, 40, -1);
    check_state("false_start", 1'b0);
    frame_and_model(8'h3C, 1'b0, 1'b1, 1'b1, 2);
    pop_one("data_glitch");
    check_state("empty_again", 1'b0);

    // Overflow: five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) frame_and_model(8'(i), 1'b0, 1'b1, 1'b1, -1);
    check_state("overflow", 1'b0);
    fork
      send_frame(8'h06, 1'b0, 1'b1, 1'b1, -1);
      begin
        @(negedge clk);
        repeat (156) @(posedge clk);
        @(negedge clk);
        oku_en_i = 1'b1;
        @(negedge clk);
        oku_en_i = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(exp_entry(8'h06, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    check_state("full_push_pop", 1'b0);
    @(negedge clk);
    hata_temizle_i = 1'b1;
    @(negedge clk);
    hata_temizle_i = 1'b0;
    tasma_m = 1'b0;
    check_state("ovf_cleared", 1'b0);
    while (q.size() > 1) pop_one("drain");

    // Reset in the middle of data bit 4 with one entry already stored.
    partial_frame(8);
    rstn_i = 1'b0;
    #1;
    q.delete();
    tasma_m = 1'b0;
    check_state("mid_reset", 1'b1);
    @(negedge clk);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    repeat (3) @(negedge clk);
    check_state("after_reset", 1'b1);

    // Receiver disable mid-frame.
    partial_frame(8);
    rx_en_i = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rx_en_i = 1'b1;
    drive_bit(1'b1, 48, -1);
    check_state("rx_en_abort", 1'b0);
    frame_and_model(8'h5A, 1'b0, 1'b1, 1'b1, -1);
    pop_one("after_abort");

    // Random frames with random configuration.
    for (int it = 0; it < 24; it++) begin
      int g;
      baud_bolen_i = 16'($urandom_range(8, 24));
      parite_i     = 2'($urandom_range(0, 3));
      dur2_i       = 1'($urandom_range(0, 1));
      g            = $urandom_range(0, 11);
      frame_and_model(8'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                      (g < 8) ? g : -1);
      check_state("rand", 1'b0);
      if ($urandom_range(0, 1) == 1) pop_one("rand_pop");
    end
    while (q.size() > 0) pop_one("final_drain");
    @(negedge clk);
    oku_en_i = 1'b1;
    @(negedge clk);
    oku_en_i = 1'b0;
    check_state("pop_empty", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alici_param.md
Name: uart_alici_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds:
- configurable data width, parity mode and stop-bit count
- 2-flop input synchroniser
- 3-sample majority voting per bit and false-start rejection
- per-frame parity and framing error flags stored alongside the data in an internal parametrised FIFO
- sticky overrun flag

Sits between the pad (rx_i) and the UART register/bus interface, which pops words through a first-word-fall-through read port.

Parameters:
VERI_W, 8, data bits per frame (legal 5..9)
FIFO_DERINLIK, 16, FIFO entries (power of 2, >=2)
SAYAC_W, 16, width of baud divisor/counter

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
baud_bolen_i  in  SAYAC_W  clocks per bit (legal >=8; changing it mid-frame is undefined)
parite_i  in  2  00 none, 01 even, 10 odd, 11 none
dur2_i  in  1  0: one stop bit, 1: two stop bits
rx_en_i  in  1  receiver enable
rx_i  in  1  serial input, asynchronous, idle high
oku_en_i  in  1  pop head entry
hata_temizle_i  in  1  clear sticky overrun
veri_o  out  VERI_W  head entry data (FWFT)
parite_hata_o  out  1  head entry parity error
cerceve_hata_o  out  1  head entry framing error
fifo_bos_o  out  1  FIFO empty
fifo_dolu_o  out  1  FIFO full
doluluk_o  out  $clog2(FIFO_DERINLIK)+1  entry count
tasma_o  out  1  sticky overrun

Behaviour:
- Reset (async assert, sync release): FSM=BOSTA, counters 0, synchroniser flops 1, FIFO pointers/count 0; veri_o=0, error outputs 0, fifo_bos_o=1, fifo_dolu_o=0, doluluk_o=0, tasma_o=0. Reset mid-frame discards the partial frame; no FIFO write.
- Input: rx_i passes through a 2-flop synchroniser to produce rx_s. Falling-edge detect on rx_s uses one extra flop.
- H = baud_bolen_i>>1. The bit counter c runs 0..baud_bolen_i-1 per bit period. Samples are taken at c=H-1, H, H+1; the bit value is the majority of the three and is decided at c=H+1.
- FSM states:
  - BOSTA: counters 0. A falling edge on rx_s with rx_en_i=1 moves to BASLA with c=0. The FIFO-full state does NOT block reception.
  - BASLA: if the voted start bit is 1 (glitch), go to BOSTA with no write; else go to VERI at the end of the bit period.
  - VERI: VERI_W bits, LSB first, shifted into a data register. After the last bit, go to PARITE if parity is enabled, else to DUR.
  - PARITE: compare the voted bit with the computed parity (even: XOR of data bits; odd: its inverse). A mismatch sets the frame's parity error.
  - DUR: one or two stop bits. Any voted stop bit of 0 sets the frame's framing error. At the decision point (c=H+1) of the final stop bit, push the frame and go to BOSTA immediately, without waiting for the end of the bit period, so back-to-back frames are caught.
- rx_en_i deassert in any non-BOSTA state: abort to BOSTA next cycle, no write.
- FIFO entry = {cerceve_hata, parite_hata, data}, VERI_W+2 bits.
- Write rules:
  - If full and no pop in the same cycle: frame dropped, tasma_o<=1.
  - If full with a simultaneous pop: write accepted, count unchanged.
  - Pop when empty is ignored.
  - Simultaneous push and pop on empty: push only.
- Pointers wrap modulo FIFO_DERINLIK. The outputs always show the head entry (combinational from storage).
- tasma_o is cleared only by hata_temizle_i. If a new overrun occurs in the same cycle as hata_temizle_i, set wins.
- Latency: pin edge to BASLA is 3 cycles. A pushed entry is visible at veri_o and fifo_bos_o=0 the cycle after the push.

Test Plan:
- baud_bolen_i=16, 8N1, serial 0xA5 -> one entry: veri_o=0xA5, errors 0, doluluk_o=1. Push occurs at 9*16+9 clocks after start-bit sync. Pop -> fifo_bos_o=1.
- Even parity, 0x07 sent with parity bit 0 (wrong) -> veri_o=0x07, parite_hata_o=1. Odd parity with correct bit -> flag 0.
- dur2_i=1, second stop bit driven 0 -> cerceve_hata_o=1. Repeat with both stop bits high -> 0.
- Low pulse of 5 clocks (H=8) on idle line -> no write, FSM back in BOSTA; 1-clock glitch inside a data bit is ignored by voting.
- FIFO_DERINLIK=4, five frames 0x01..0x05 without pops -> 0x01..0x04 stored, tasma_o=1, fifo_dolu_o=1. Pop in the push cycle of a sixth frame -> write accepted. hata_temizle_i -> tasma_o=0.
- rstn_i low mid-data-bit 4, and separately rx_en_i=0 mid-frame -> no entry written, all outputs at reset values (reset case). Next clean frame is received correctly.
